// File: rtl/shift_add_multiplier_16_pkg.sv
// Shared constants and state encoding for the shift-and-add multiplier.
package shift_add_multiplier_16_pkg;

    localparam int MUL_WIDTH = 16;
    localparam int MUL_CNT_W = 5;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } mul_state_e;

endpackage

// File: rtl/adder16_cla.sv
// 16-bit carry-lookahead adder: four 4-bit lookahead groups joined by a
// second-level group lookahead. Purely combinational.
module adder16_cla (
    input  logic [15:0] A,
    input  logic [15:0] B,
    input  logic        Cin,
    output logic [15:0] S,
    output logic        Cout
);

    logic [15:0] g_s;
    logic [15:0] p_s;
    logic [3:0]  gg_s;
    logic [3:0]  gp_s;
    logic [4:0]  gc_s;
    logic [15:0] c_s;

    assign g_s = A & B;
    assign p_s = A ^ B;

    // Group generate/propagate, group carries, then in-group carries and sum.
    always_comb begin
        c_s = 16'h0000;
        for (int k = 0; k < 4; k++) begin
            gg_s[k] = g_s[4*k+3]
                    | (p_s[4*k+3] & g_s[4*k+2])
                    | (p_s[4*k+3] & p_s[4*k+2] & g_s[4*k+1])
                    | (p_s[4*k+3] & p_s[4*k+2] & p_s[4*k+1] & g_s[4*k]);
            gp_s[k] = p_s[4*k+3] & p_s[4*k+2] & p_s[4*k+1] & p_s[4*k];
        end
        gc_s[0] = Cin;
        gc_s[1] = gg_s[0] | (gp_s[0] & gc_s[0]);
        gc_s[2] = gg_s[1] | (gp_s[1] & gg_s[0]) | (gp_s[1] & gp_s[0] & gc_s[0]);
        gc_s[3] = gg_s[2] | (gp_s[2] & gg_s[1]) | (gp_s[2] & gp_s[1] & gg_s[0])
                | (gp_s[2] & gp_s[1] & gp_s[0] & gc_s[0]);
        gc_s[4] = gg_s[3] | (gp_s[3] & gg_s[2]) | (gp_s[3] & gp_s[2] & gg_s[1])
                | (gp_s[3] & gp_s[2] & gp_s[1] & gg_s[0])
                | (gp_s[3] & gp_s[2] & gp_s[1] & gp_s[0] & gc_s[0]);
        for (int k = 0; k < 4; k++) begin
            c_s[4*k]   = gc_s[k];
            c_s[4*k+1] = g_s[4*k] | (p_s[4*k] & gc_s[k]);
            c_s[4*k+2] = g_s[4*k+1] | (p_s[4*k+1] & g_s[4*k])
                       | (p_s[4*k+1] & p_s[4*k] & gc_s[k]);
            c_s[4*k+3] = g_s[4*k+2] | (p_s[4*k+2] & g_s[4*k+1])
                       | (p_s[4*k+2] & p_s[4*k+1] & g_s[4*k])
                       | (p_s[4*k+2] & p_s[4*k+1] & p_s[4*k] & gc_s[k]);
        end
    end

    assign S    = p_s ^ c_s;
    assign Cout = gc_s[4];

endmodule

// File: rtl/shift_add_multiplier_16.sv
// Sequential unsigned multiplier: one add-and-shift step per clock through the
// shared 16-bit CLA; start/done handshake with fixed WIDTH-edge latency.
module shift_add_multiplier_16
    import shift_add_multiplier_16_pkg::*;
#(
    parameter int WIDTH = MUL_WIDTH
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   product
);

    localparam int CNT_W = $clog2(WIDTH) + 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

    mul_state_e          state_r;
    mul_state_e          state_s;
    logic                accept_s;
    logic                last_s;
    logic [CNT_W-1:0]    count_r;
    logic [WIDTH:0]      acc_r;
    logic [WIDTH-1:0]    mq_r;
    logic [WIDTH-1:0]    mcand_r;
    logic [2*WIDTH-1:0]  product_r;
    logic                busy_r;
    logic                done_r;
    logic [WIDTH-1:0]    addend_s;
    logic [WIDTH-1:0]    sum_s;
    logic                cout_s;

    assign addend_s = mq_r[0] ? mcand_r : {WIDTH{1'b0}};
    assign last_s   = (count_r == LAST_CNT);

    adder16_cla u_adder (
        .A    (acc_r[WIDTH-1:0]),
        .B    (addend_s),
        .Cin  (1'b0),
        .S    (sum_s),
        .Cout (cout_s)
    );

    // Next-state decode; DONE may accept a new request back-to-back.
    always_comb begin
        state_s  = state_r;
        accept_s = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    state_s  = ST_RUN;
                    accept_s = 1'b1;
                end else begin
                    state_s  = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (last_s) begin
                    state_s = ST_DONE;
                end else begin
                    state_s = ST_RUN;
                end
            end
            ST_DONE: begin
                if (start) begin
                    state_s  = ST_RUN;
                    accept_s = 1'b1;
                end else begin
                    state_s  = ST_IDLE;
                end
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Operand capture, add-and-shift iteration and result register.
    always_ff @(posedge clk) begin
        if (rst) begin
            mcand_r   <= {WIDTH{1'b0}};
            mq_r      <= {WIDTH{1'b0}};
            acc_r     <= {(WIDTH+1){1'b0}};
            count_r   <= {CNT_W{1'b0}};
            product_r <= {(2*WIDTH){1'b0}};
        end else if (accept_s) begin
            mcand_r <= a;
            mq_r    <= b;
            acc_r   <= {(WIDTH+1){1'b0}};
            count_r <= {CNT_W{1'b0}};
        end else if (state_r == ST_RUN) begin
            // {acc, mq} <= {cout, sum, mq} >> 1
            acc_r   <= {1'b0, cout_s, sum_s[WIDTH-1:1]};
            mq_r    <= {sum_s[0], mq_r[WIDTH-1:1]};
            count_r <= count_r + CNT_W'(1);
            if (last_s) begin
                product_r <= {cout_s, sum_s, mq_r[WIDTH-1:1]};
            end
        end
    end

    // Status flags registered from the next state so they track state_r.
    always_ff @(posedge clk) begin
        if (rst) begin
            busy_r <= 1'b0;
            done_r <= 1'b0;
        end else begin
            busy_r <= (state_s == ST_RUN);
            done_r <= (state_s == ST_DONE);
        end
    end

    assign busy    = busy_r;
    assign done    = done_r;
    assign product = product_r;

endmodule

// File: tb/tb_shift_add_multiplier_16.sv
// Directed plus randomized bench for shift_add_multiplier_16, checked against
// plain integer multiplication.
module tb_shift_add_multiplier_16;

    logic        clk;
    logic        rst;
    logic        start;
    logic [15:0] a;
    logic [15:0] b;
    logic        busy;
    logic        done;
    logic [31:0] product;

    int pass_cnt = 0;
    int total_cnt = 0;

    shift_add_multiplier_16 dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .a       (a),
        .b       (b),
        .busy    (busy),
        .done    (done),
        .product (product)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] ref_mul(input logic [15:0] x, input logic [15:0] y);
        longint unsigned p;
        p = longint'(x) * longint'(y);
        return p[31:0];
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total_cnt++;
        assert (obs === exp) begin
            pass_cnt++;
        end else begin
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drive start for one edge with the given operands; leaves start low.
    task automatic accept(input logic [15:0] x, input logic [15:0] y);
        @(negedge clk);
        a = x;
        b = y;
        start = 1'b1;
        tick();
        start = 1'b0;
        check("busy_after_accept", 64'(busy), 64'd1);
    endtask

    // Wait (bounded) for done; check the edge count and the product.
    task automatic wait_done(input string tag, input int exp_edges, input logic [31:0] exp_prod);
        int n;
        n = 0;
        while (done !== 1'b1 && n < 60) begin
            tick();
            n++;
        end
        check({tag, "_latency"}, 64'(n), 64'(exp_edges));
        check({tag, "_product"}, 64'(product), 64'(exp_prod));
        check({tag, "_busy_at_done"}, 64'(busy), 64'd0);
    endtask

    // Count done pulses over a window; expected to stay silent.
    task automatic quiet(input string tag, input int cycles);
        int pulses;
        pulses = 0;
        for (int i = 0; i < cycles; i++) begin
            tick();
            if (done === 1'b1) pulses++;
        end
        check(tag, 64'(pulses), 64'd0);
    endtask

    initial begin
        logic [15:0] ra;
        logic [15:0] rb;
        logic [31:0] held;

        rst = 1'b1;
        start = 1'b0;
        a = 16'd0;
        b = 16'd0;

        // Reset then idle.
        tick();
        tick();
        rst = 1'b0;
        check("reset_busy", 64'(busy), 64'd0);
        check("reset_done", 64'(done), 64'd0);
        check("reset_product", 64'(product), 64'd0);
        quiet("idle_no_done", 40);

        // Zero operands still take the full latency.
        accept(16'd0, 16'd0);
        wait_done("zero", 16, 32'h0000_0000);
        tick();
        check("zero_done_one_cycle", 64'(done), 64'd0);

        // Typical value, then hold through idle.
        accept(16'd9431, 16'd1032);
        a = 16'hFFFF;
        b = 16'hFFFF;
        wait_done("typical", 16, 32'h0094_82B8);
        check("typical_model", 64'(product), 64'(ref_mul(16'd9431, 16'd1032)));
        held = product;
        quiet("typical_idle", 20);
        check("typical_held", 64'(product), 64'(held));

        // Max operands with start held high: back-to-back accept in DONE.
        @(negedge clk);
        a = 16'hFFFF;
        b = 16'hFFFF;
        start = 1'b1;
        tick();
        check("b2b_busy", 64'(busy), 64'd1);
        a = 16'd65000;
        b = 16'd1032;
        wait_done("max", 16, 32'hFFFE_0001);
        tick();
        start = 1'b0;
        check("b2b_reaccept_busy", 64'(busy), 64'd1);
        check("b2b_reaccept_done", 64'(done), 64'd0);
        check("b2b_product_kept_on_accept", 64'(product), 64'hFFFE_0001);
        wait_done("b2b_second", 16, 32'h03FF_8F40);

        // Start while busy is ignored.
        accept(16'd3, 16'd5);
        repeat (4) tick();
        @(negedge clk);
        a = 16'd7;
        b = 16'd7;
        start = 1'b1;
        tick();
        start = 1'b0;
        wait_done("ignore_start", 11, 32'h0000_000F);
        quiet("ignore_start_single_done", 20);

        // Reset mid-operation abandons it.
        accept(16'd100, 16'd200);
        repeat (7) tick();
        @(negedge clk);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("midrst_busy", 64'(busy), 64'd0);
        check("midrst_done", 64'(done), 64'd0);
        check("midrst_product", 64'(product), 64'd0);
        quiet("midrst_no_done", 30);
        accept(16'd100, 16'd200);
        wait_done("after_rst", 16, 32'h0000_4E20);

        // Randomized operands against the reference model.
        for (int i = 0; i < 10; i++) begin
            ra = 16'($urandom);
            rb = 16'($urandom);
            if (i == 0) ra = 16'hFFFF;
            if (i == 1) rb = 16'h0001;
            accept(ra, rb);
            a = 16'($urandom);
            b = 16'($urandom);
            wait_done("random", 16, ref_mul(ra, rb));
        end

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
